// File: rtl/nonogram_pkg.sv
// Shared constants, count vector type and feeder state encoding for the nonogram solver.
package nonogram_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned MAX_LINES = 22;
  localparam int unsigned CNT_W     = 7;

  typedef logic [MAX_LINES-1:0][CNT_W-1:0] amnt_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_INDEX,
    S_OPT_A,
    S_OPT_B,
    S_PASS_END,
    S_DONE,
    S_STUCK
  } feeder_state_t;

  function automatic logic is_busy(feeder_state_t s);
    return s inside {S_START, S_INDEX, S_OPT_A, S_OPT_B, S_PASS_END};
  endfunction

endpackage

// File: rtl/option_fifo.sv
// Circular option buffer: one write and one read per cycle, combinational head word.
module option_fifo #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head_c,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [AW:0]       count;
  logic              do_pop;
  logic              do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full buffer can still take the push.
  assign do_push = push && (!full || do_pop);
  assign head_c  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/option_feeder.sv
// Streams line-index and option words to the solver pass by pass, re-queuing survivors
// and tracking per-line option counts until solved or a pass makes no progress.
module option_feeder #(
  parameter int unsigned MAX_LINES = nonogram_pkg::MAX_LINES,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned WORD_W    = nonogram_pkg::WORD_W,
  parameter int unsigned CNT_W     = nonogram_pkg::CNT_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         num_rows,
  input  logic [3:0]                         num_cols,
  input  logic                               load_valid,
  input  logic [WORD_W-1:0]                  load_word,
  output logic                               load_ready,
  input  logic                               load_done,
  input  logic [MAX_LINES-1:0][CNT_W-1:0]    init_amnt,
  output logic                               started,
  output logic [WORD_W-1:0]                  option,
  output logic [MAX_LINES-1:0][CNT_W-1:0]    old_options_amnt,
  input  logic [WORD_W-1:0]                  new_option,
  input  logic                               put_back_to_FIFO,
  input  logic                               solved,
  output logic                               busy,
  output logic                               done,
  output logic                               stuck,
  output logic                               overflow
);
  import nonogram_pkg::*;

  localparam int unsigned LINE_W = $clog2(MAX_LINES);

  feeder_state_t                  state, state_next;
  logic [LINE_W-1:0]              line_ptr, line_next, last_line;
  logic [CNT_W-1:0]               rem;
  logic [CNT_W-1:0]               idx_cnt_c;
  logic [MAX_LINES-1:0][CNT_W-1:0] new_amnt;
  logic                           pushed;

  logic              loading_c, load_push_c, pb_push_c, load_take_c, pass_adv_c;
  logic              fifo_wr_c, fifo_pop_c, fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_head_c, fifo_wdata_c;

  logic              started_c, busy_c, load_ready_c;
  logic [WORD_W-1:0] option_c;

  assign loading_c   = (state == S_IDLE) || (state == S_LOAD);
  assign load_push_c = loading_c && load_valid;
  assign load_take_c = loading_c && load_done;
  // One re-queue per option: the OPT_B request is ignored if OPT_A already pushed.
  assign pb_push_c   = put_back_to_FIFO &&
                       ((state == S_OPT_A) || ((state == S_OPT_B) && !pushed));
  assign pass_adv_c  = (state == S_PASS_END) && (state_next == S_INDEX);

  assign fifo_wr_c    = load_push_c || pb_push_c;
  assign fifo_wdata_c = load_push_c ? load_word : new_option;
  assign fifo_pop_c   = (state_next == S_OPT_A);

  option_fifo #(.DEPTH(DEPTH), .WORD_W(WORD_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_wr_c),
    .push_data (fifo_wdata_c),
    .pop       (fifo_pop_c),
    .head_c    (fifo_head_c),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state and next line pointer
  always_comb begin
    state_next = state;
    line_next  = line_ptr;
    unique case (state)
      S_IDLE: begin
        if (load_done)       state_next = S_START;
        else if (load_valid) state_next = S_LOAD;
      end
      S_LOAD:  if (load_done) state_next = S_START;
      S_START: begin
        state_next = S_INDEX;
        line_next  = '0;
      end
      S_INDEX: begin
        if (old_options_amnt[line_ptr] != '0) begin
          state_next = (fifo_empty) ? S_INDEX : S_OPT_A;
        end else if (line_ptr == last_line) begin
          state_next = S_PASS_END;
        end else begin
          line_next = line_ptr + LINE_W'(1);
        end
      end
      S_OPT_A: state_next = S_OPT_B;
      S_OPT_B: begin
        if (rem != CNT_W'(1)) begin
          state_next = S_OPT_A;
        end else if (line_ptr == last_line) begin
          state_next = S_PASS_END;
        end else begin
          state_next = S_INDEX;
          line_next  = line_ptr + LINE_W'(1);
        end
      end
      S_PASS_END: begin
        line_next = '0;
        if (new_amnt == old_options_amnt) state_next = S_STUCK;
        else                              state_next = S_INDEX;
      end
      S_DONE:  state_next = S_DONE;
      S_STUCK: state_next = S_STUCK;
      default: state_next = S_IDLE;
    endcase
    if (solved && is_busy(state)) state_next = S_DONE;
  end

  // Next values of the registered outputs
  always_comb begin
    started_c    = (state_next == S_START);
    busy_c       = is_busy(state_next);
    load_ready_c = (state_next == S_IDLE) || (state_next == S_LOAD);
    idx_cnt_c    = (state == S_PASS_END) ? new_amnt[line_next] : old_options_amnt[line_next];
    option_c     = '0;
    unique case (state_next)
      S_INDEX: if (idx_cnt_c != '0) option_c = WORD_W'(line_next);
      S_OPT_A: option_c = fifo_head_c;
      S_OPT_B: option_c = option;
      default: option_c = '0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_ptr         <= '0;
      last_line        <= '0;
      rem              <= '0;
      pushed           <= 1'b0;
      new_amnt         <= '0;
      old_options_amnt <= '0;
      started          <= 1'b0;
      option           <= '0;
      busy             <= 1'b0;
      load_ready       <= 1'b0;
      done             <= 1'b0;
      stuck            <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      line_ptr <= line_next;
      pushed   <= (state == S_OPT_A) && put_back_to_FIFO;
      if (state == S_INDEX)      rem <= old_options_amnt[line_ptr];
      else if (state == S_OPT_B) rem <= rem - CNT_W'(1);

      if (load_take_c) begin
        last_line        <= LINE_W'(5'(num_rows) + 5'(num_cols) - 5'd1);
        old_options_amnt <= init_amnt;
      end

      if (state == S_START) begin
        new_amnt <= '0;
      end else if (pass_adv_c) begin
        old_options_amnt <= new_amnt;
        new_amnt         <= '0;
      end else if (pb_push_c) begin
        new_amnt[line_ptr] <= new_amnt[line_ptr] + CNT_W'(1);
      end

      started    <= started_c;
      option     <= option_c;
      busy       <= busy_c;
      load_ready <= load_ready_c;
      if (state_next == S_DONE)  done  <= 1'b1;
      if (state_next == S_STUCK) stuck <= 1'b1;
      if (fifo_wr_c && fifo_full && !fifo_pop_c) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_option_feeder.sv
// Directed bench for option_feeder: expected per-cycle stream built from a buffer model.
module tb_option_feeder;
  import nonogram_pkg::*;

  typedef struct packed {
    logic        st;
    logic [15:0] opt;
    logic        pb;
    logic        sv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  num_rows, num_cols;
  logic        load_valid, load_done, load_ready;
  logic [15:0] load_word;
  amnt_t       init_amnt, old_options_amnt;
  logic        started, busy, done, stuck, overflow;
  logic [15:0] option, new_option;
  logic        put_back_to_FIFO, solved;

  exp_t        exq[$];
  logic [15:0] mq[$];
  logic [15:0] ldq[$];
  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  option_feeder dut (
    .clk              (clk),
    .rst              (rst),
    .num_rows         (num_rows),
    .num_cols         (num_cols),
    .load_valid       (load_valid),
    .load_word        (load_word),
    .load_ready       (load_ready),
    .load_done        (load_done),
    .init_amnt        (init_amnt),
    .started          (started),
    .option           (option),
    .old_options_amnt (old_options_amnt),
    .new_option       (new_option),
    .put_back_to_FIFO (put_back_to_FIFO),
    .solved           (solved),
    .busy             (busy),
    .done             (done),
    .stuck            (stuck),
    .overflow         (overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".started"}, 32'(started), 32'd0);
    check({tag, ".option"}, 32'(option), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".done"}, 32'(done), 32'd0);
    check({tag, ".stuck"}, 32'(stuck), 32'd0);
    check({tag, ".overflow"}, 32'(overflow), 32'd0);
    check({tag, ".load_ready"}, 32'(load_ready), 32'd0);
    check({tag, ".amnt_or"}, 32'(|old_options_amnt), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_all_zero(tag);
    tick();
    rst = 1'b0;
    mq.delete();
    exq.delete();
    tick();
    check({tag, ".ready_after"}, 32'(load_ready), 32'd1);
  endtask

  task automatic do_load(input logic [3:0] r, input logic [3:0] c, input amnt_t a);
    while (ldq.size() > 0) begin
      load_valid = 1'b1;
      load_word  = ldq.pop_front();
      mq.push_back(load_word);
      tick();
    end
    load_valid = 1'b0;
    num_rows   = r;
    num_cols   = c;
    init_amnt  = a;
    load_done  = 1'b1;
    tick();
    load_done  = 1'b0;
    exq.push_back('{st: 1'b1, opt: 16'h0, pb: 1'b0, sv: 1'b0});
  endtask

  // Model one pass over the buffer model; mask bit j puts back the j-th option of the pass.
  task automatic expect_pass(input int nl, input amnt_t cnt, input logic [63:0] mask,
                             input logic sv, output amnt_t nc);
    int          j;
    logic [15:0] w;
    logic        pb;
    j  = 0;
    nc = '0;
    for (int l = 0; l < nl; l++) begin
      if (cnt[l] == '0) begin
        exq.push_back('{st: 1'b0, opt: 16'h0, pb: 1'b0, sv: 1'b0});
      end else begin
        exq.push_back('{st: 1'b0, opt: 16'(l), pb: 1'b0, sv: 1'b0});
        for (int k = 0; k < int'(cnt[l]); k++) begin
          w  = mq.pop_front();
          pb = mask[j];
          j++;
          exq.push_back('{st: 1'b0, opt: w, pb: pb, sv: 1'b0});
          exq.push_back('{st: 1'b0, opt: w, pb: 1'b0, sv: 1'b0});
          if (pb) begin
            mq.push_back(w);
            nc[l] = nc[l] + 7'd1;
          end
        end
      end
    end
    exq.push_back('{st: 1'b0, opt: 16'h0, pb: 1'b0, sv: sv});
  endtask

  task automatic run_stream(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      if (exq.size() == 0) begin
        check($sformatf("%s.queue_empty[%0d]", tag, i), 32'd1, 32'd0);
        break;
      end
      e = exq.pop_front();
      check($sformatf("%s.started[%0d]", tag, i), 32'(started), 32'(e.st));
      check($sformatf("%s.option[%0d]", tag, i), 32'(option), 32'(e.opt));
      put_back_to_FIFO = e.pb;
      new_option       = e.opt;
      solved           = e.sv;
      tick();
    end
    put_back_to_FIFO = 1'b0;
    solved           = 1'b0;
  endtask

  initial begin
    amnt_t a, nc, nc2;
    rst = 1'b1; num_rows = '0; num_cols = '0; load_valid = 1'b0; load_word = '0;
    load_done = 1'b0; init_amnt = '0; new_option = '0; put_back_to_FIFO = 1'b0; solved = 1'b0;

    // Reset state
    #2;
    do_reset("rst0");

    // 2x2 board, one option per line, solved at pass end
    ldq = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    a = '0;
    for (int l = 0; l < 4; l++) a[l] = 7'd1;
    do_load(4'd2, 4'd2, a);
    check("b2.amnt0", 32'(old_options_amnt[0]), 32'd1);
    check("b2.busy", 32'(busy), 32'd1);
    check("b2.ready", 32'(load_ready), 32'd0);
    expect_pass(4, a, 64'h0, 1'b1, nc);
    run_stream("b2", exq.size());
    check("b2.done", 32'(done), 32'd1);
    check("b2.busy_end", 32'(busy), 32'd0);
    check("b2.opt_end", 32'(option), 32'd0);
    check("b2.stuck", 32'(stuck), 32'd0);
    do_reset("rst1");

    // 11x11 X pattern, no put-backs, solved after the last column
    a = '0;
    for (int l = 0; l < 22; l++) begin
      logic [10:0] x;
      x = 11'h7ff & ~((11'd1 << (l % 11)) | (11'd1 << (10 - (l % 11))));
      ldq.push_back(16'(x));
      a[l] = 7'd1;
    end
    do_load(4'd11, 4'd11, a);
    expect_pass(22, a, 64'h0, 1'b1, nc);
    check("x11.stream_len", 32'(exq.size()), 32'd68);
    run_stream("x11", exq.size());
    check("x11.done", 32'(done), 32'd1);
    check("x11.busy", 32'(busy), 32'd0);
    do_reset("rst2");

    // Line 0 keeps two of three options; second pass puts everything back -> stuck
    ldq = '{16'h0a01, 16'h0a02, 16'h0a03, 16'h0b01};
    a = '0;
    a[0] = 7'd3;
    a[1] = 7'd1;
    do_load(4'd1, 4'd1, a);
    expect_pass(2, a, 64'hd, 1'b0, nc);
    expect_pass(2, nc, 64'h7, 1'b0, nc2);
    run_stream("surv", exq.size());
    check("surv.amnt0", 32'(old_options_amnt[0]), 32'd2);
    check("surv.amnt1", 32'(old_options_amnt[1]), 32'd1);
    check("stk.stuck", 32'(stuck), 32'd1);
    check("stk.busy", 32'(busy), 32'd0);
    check("stk.done", 32'(done), 32'd0);
    check("stk.option", 32'(option), 32'd0);
    do_reset("rst3");

    // Middle line with zero options is skipped in one cycle
    ldq = '{16'h00c0, 16'h00c2};
    a = '0;
    a[0] = 7'd1;
    a[2] = 7'd1;
    do_load(4'd2, 4'd1, a);
    expect_pass(3, a, 64'h0, 1'b1, nc);
    run_stream("skip", exq.size());
    check("skip.done", 32'(done), 32'd1);
    do_reset("rst4");

    // Reset during OPT_B of line 5
    a = '0;
    for (int l = 0; l < 6; l++) begin
      ldq.push_back(16'h0100 + 16'(l));
      a[l] = 7'd1;
    end
    do_load(4'd3, 4'd3, a);
    expect_pass(6, a, 64'h0, 1'b0, nc);
    run_stream("mid", 18);
    check("mid.optb5", 32'(option), 32'h0105);
    check("mid.busy", 32'(busy), 32'd1);
    do_reset("midrst");
    check("midrst.busy", 32'(busy), 32'd0);

    // Overflow on the write after the buffer fills
    for (int i = 0; i < 512; i++) begin
      load_valid = 1'b1;
      load_word  = 16'(i);
      tick();
    end
    check("ovf.before", 32'(overflow), 32'd0);
    tick();
    load_valid = 1'b0;
    check("ovf.after", 32'(overflow), 32'd1);
    check("ovf.ready", 32'(load_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
